// File: rtl/btn_arb_pkg.sv
// Shared types and constants for the button event arbiter.
package btn_arb_pkg;
  localparam int LOCKOUT_W          = 15;
  localparam int LOCKOUT_CYCLES_DEF = 20000;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;
endpackage

// File: rtl/btn_lockout.sv
// Per-button front end: 2-flop synchronizer, rising-edge detect, and a
// lockout counter that swallows bounce edges. press_o is a one-cycle strobe.
module btn_lockout
  import btn_arb_pkg::*;
#(
  parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  logic                 sync1_q, sync2_q, prev_q, press_q;
  logic [LOCKOUT_W-1:0] cnt_q, cnt_d;
  logic                 rise;
  logic                 cnt_zero;

  assign rise     = sync2_q & ~prev_q;
  assign cnt_zero = (cnt_q == '0);
  assign press_o  = press_q;

  // Lockout counter: arm on an accepted edge, otherwise count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (rise && cnt_zero)
      cnt_d = LOCKOUT_W'(LOCKOUT_CYCLES);
    else if (!cnt_zero)
      cnt_d = cnt_q - LOCKOUT_W'(1);
  end

  // Synchronizer, edge history, registered press strobe and counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      press_q <= rise & cnt_zero;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Debounced push-button event arbiter: per-button lockout front ends feed a
// pending vector, served round-robin through a valid/ready event port.
// Optional sticky lost-press flag enabled by defining BTN_ARB_OVERFLOW_EN.
module button_event_arbiter
  import btn_arb_pkg::*;
#(
  parameter int NUM_BTN        = 4,
  parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_BTN-1:0]         button,
  output logic                       evt_valid,
  output logic [$clog2(NUM_BTN)-1:0] evt_id,
  input  logic                       evt_ready,
  output logic [NUM_BTN-1:0]         pending,
  output logic                       overflow
);

  localparam int IDW = $clog2(NUM_BTN);

  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] pending_q, pending_d, clr_mask;
  logic [IDW-1:0]     evt_id_q, evt_id_d;
  logic [IDW-1:0]     last_grant_q, last_grant_d;
  logic [IDW-1:0]     winner, idx;
  logic               found;
  arb_state_e         state_q, state_d;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_lockout #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_lock (
      .clk     (clk),
      .reset   (reset),
      .btn_i   (button[g]),
      .press_o (press[g])
    );
  end

  assign evt_valid = (state_q == OFFER);
  assign evt_id    = evt_id_q;
  assign pending   = pending_q;

  // Round-robin pick: first pending index after the last granted one.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      idx = IDW'((int'(last_grant_q) + k) % NUM_BTN);
      if (!found && pending_q[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Arbiter next state; a new press on the winner re-sets its pending bit.
  always_comb begin
    state_d      = state_q;
    evt_id_d     = evt_id_q;
    last_grant_d = last_grant_q;
    clr_mask     = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          evt_id_d         = winner;
          clr_mask[winner] = 1'b1;
          state_d          = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          last_grant_d = evt_id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    pending_d = (pending_q & ~clr_mask) | press;
  end

  // Arbiter state registers; index 0 is served first after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      evt_id_q     <= '0;
      last_grant_q <= IDW'(NUM_BTN - 1);
      pending_q    <= '0;
    end else begin
      state_q      <= state_d;
      evt_id_q     <= evt_id_d;
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
    end
  end

`ifdef BTN_ARB_OVERFLOW_EN
  logic overflow_q, overflow_d;

  // A press lands on a button that still has an unserved press.
  always_comb overflow_d = overflow_q | (|(press & pending_q & ~clr_mask));

  // Sticky lost-press flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: directed scenarios plus a random phase,
// all checked every cycle against a press/arbitration reference model.
module tb_button_event_arbiter;
  localparam int NB = 4;
  localparam int L  = 8;
`ifdef BTN_ARB_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, evt_valid, evt_ready, overflow;
  logic [NB-1:0] button, pending;
  logic [1:0]    evt_id;

  button_event_arbiter #(.NUM_BTN(NB), .LOCKOUT_CYCLES(L)) dut (
    .clk(clk), .reset(reset), .button(button), .evt_valid(evt_valid),
    .evt_id(evt_id), .evt_ready(evt_ready), .pending(pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int            cyc;
  logic [NB-1:0] smp [0:8191];
  int            last_acc [NB];
  logic [NB-1:0] strobe_m, pend_m;
  logic          ov_m, valid_m;
  int            id_m, lg_m;
  int            hs[$];
  int            hsc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    strobe_m = '0; pend_m = '0; ov_m = 1'b0; valid_m = 1'b0;
    id_m = 0; lg_m = NB - 1;
    for (int i = 0; i < NB; i++) last_acc[i] = -100000;
  endtask

  // One clock edge of the reference: presses appear in pending three edges
  // after the level is sampled, if more than L edges since the last accepted one.
  task automatic model_edge();
    logic [NB-1:0] clr;
    bit s2, s3;
    if (reset) begin
      smp[cyc] = '0;
      if (cyc >= 1) smp[cyc-1] = '0;
      if (cyc >= 2) smp[cyc-2] = '0;
      model_reset();
    end else begin
      smp[cyc] = button;
      clr = '0;
      if (!valid_m) begin
        if (pend_m != '0) begin
          for (int k = 1; k <= NB; k++) begin
            if (!valid_m && pend_m[(lg_m + k) % NB]) begin
              id_m = (lg_m + k) % NB;
              clr[id_m] = 1'b1;
              valid_m = 1'b1;
            end
          end
        end
      end else if (evt_ready) begin
        lg_m = id_m;
        valid_m = 1'b0;
      end
      if ((strobe_m & pend_m & ~clr) != '0) ov_m = 1'b1;
      pend_m = (pend_m & ~clr) | strobe_m;
      for (int i = 0; i < NB; i++) begin
        s2 = (cyc >= 2) ? smp[cyc-2][i] : 1'b0;
        s3 = (cyc >= 3) ? smp[cyc-3][i] : 1'b0;
        strobe_m[i] = 1'b0;
        if (s2 && !s3 && (cyc - last_acc[i] > L)) begin
          strobe_m[i] = 1'b1;
          last_acc[i] = cyc;
        end
      end
    end
    cyc++;
  endtask

  task automatic step();
    if (evt_valid && evt_ready && !reset) begin
      hs.push_back(int'(evt_id));
      hsc.push_back(cyc);
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", evt_valid, valid_m);
    if (valid_m) chk("id", evt_id, id_m);
    chk("pending", pending, pend_m);
    chk("overflow", overflow, OVF_EN ? ov_m : 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      step();
      if (evt_valid) ok = 1'b1;
    end
  endtask

  initial begin
    bit ok;
    int rst_left;
    cyc = 0; reset = 1'b1; button = '0; evt_ready = 1'b0;
    model_reset();
    idle(3);
    chk("rst_valid", evt_valid, 0);
    chk("rst_id", evt_id, 0);
    chk("rst_pend", pending, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;

    // single press on button 2: offered on edge 4, gone on edge 5
    evt_ready = 1'b1; button = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 3) chk("lat_early", evt_valid, 0);
      if (i == 4) begin
        chk("lat_valid", evt_valid, 1);
        chk("lat_id", evt_id, 2);
        chk("lat_pclr", pending[2], 0);
      end
      if (i == 5) chk("lat_drop", evt_valid, 0);
    end
    button = '0; idle(12);

    // bounce on button 0
    hs.delete(); hsc.delete();
    for (int i = 0; i < 6; i++) begin
      button[0] = (i % 2 == 0);
      step();
    end
    button = '0; idle(20);
    chk("bnc_cnt", hs.size(), 1);
    chk("bnc_id", hs.size() > 0 ? hs[0] : 99, 0);

    // simultaneous presses 0,1,3 from a fresh round-robin pointer
    reset = 1'b1; idle(2); reset = 1'b0;
    hs.delete(); hsc.delete();
    button = 4'b1011; idle(15); button = '0; idle(12);
    chk("sim_cnt", hs.size(), 3);
    if (hs.size() == 3) begin
      chk("sim_id0", hs[0], 0);
      chk("sim_id1", hs[1], 1);
      chk("sim_id2", hs[2], 3);
      chk("sim_gap1", hsc[1] - hsc[0], 2);
      chk("sim_gap2", hsc[2] - hsc[1], 2);
    end

    // backpressure: offer must hold for 10 cycles, then accept
    evt_ready = 1'b0; button = 4'b0100;
    wait_valid(10, ok);
    chk("bp_seen", ok, 1);
    button = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_v", evt_valid, 1);
      chk("bp_hold_id", evt_id, 2);
    end
    evt_ready = 1'b1; step();
    chk("bp_idle", evt_valid, 0);
    idle(12);

    // overflow: button 0 blocks the port, button 1 pressed twice
    reset = 1'b1; idle(2); reset = 1'b0;
    hs.delete(); hsc.delete();
    evt_ready = 1'b0;
    button = 4'b0001; idle(2); button = '0; idle(3);
    button = 4'b0010; idle(2); button = '0; idle(8);
    button = 4'b0010; idle(2); button = '0; idle(8);
    chk("ovf_flag", overflow, OVF_EN);
    chk("ovf_pend1", pending[1], 1);
    evt_ready = 1'b1; idle(15);
    chk("ovf_cnt", hs.size(), 2);
    chk("ovf_first", hs.size() > 0 ? hs[0] : 99, 0);
    chk("ovf_second", hs.size() > 1 ? hs[1] : 99, 1);

    // reset while an event is offered
    evt_ready = 1'b0; button = 4'b1000;
    wait_valid(10, ok);
    chk("rso_seen", ok, 1);
    button = '0; reset = 1'b1; step();
    chk("rso_valid", evt_valid, 0);
    chk("rso_pend", pending, 0);
    chk("rso_ovf", overflow, 0);
    step(); reset = 1'b0; idle(2);
    evt_ready = 1'b1; button = 4'b0001;
    wait_valid(10, ok);
    chk("rso_again", ok, 1);
    chk("rso_id", evt_id, 0);
    button = '0; idle(12);

    // button held high through reset release yields one event
    button = 4'b1000; reset = 1'b1; idle(3); reset = 1'b0;
    hs.delete(); hsc.delete();
    idle(20);
    chk("held_cnt", hs.size(), 1);
    chk("held_id", hs.size() > 0 ? hs[0] : 99, 3);
    button = '0; idle(12);

    // random traffic
    rst_left = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 5) == 0) button[b] = ~button[b];
      evt_ready = ($urandom_range(0, 9) < 7);
      if (rst_left == 0 && $urandom_range(0, 399) == 0) rst_left = 2;
      reset = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
